// File: rtl/edge_buffer_collector.sv
// Round-robin collector for a bank of single-word hold buffers; presents {channel, data} on a ready/valid stream.
// Optional define EDGE_COLLECTOR_TIMESTAMP_EN prepends a free-running timestamp captured at grant.
module edge_buffer_collector #(
  parameter int nchan    = 4,
  parameter int bitwidth = 24,
  parameter int chanbits = 2,
  parameter int tswidth  = 16,
`ifdef EDGE_COLLECTOR_TIMESTAMP_EN
  localparam int TsW     = tswidth,
`else
  localparam int TsW     = 0,
`endif
  localparam int OutW    = TsW + chanbits + bitwidth
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [nchan-1:0]            avail,
  input  logic [nchan*bitwidth-1:0]   q,
  output logic [nchan-1:0]            clear,
  output logic [OutW-1:0]             out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  if (tswidth < 1 || (1 << chanbits) < nchan || nchan < 2) begin : g_param_check
    $error("edge_buffer_collector: invalid parameters");
  end

  typedef enum logic [1:0] {SCAN, PRESENT, RELEASE} state_t;

  state_t                state_q, state_d;
  logic [chanbits-1:0]   ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic [OutW-1:0]       data_q, data_d;
  logic [nchan-1:0]      clear_q, clear_d;

  logic                  found;
  logic [chanbits-1:0]   gnt;
  int unsigned           idx;

`ifdef EDGE_COLLECTOR_TIMESTAMP_EN
  logic [tswidth-1:0]    ts_q;

  always_ff @(posedge clock) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end
`endif

  // First set avail bit searching upward from ptr, wrapping at nchan-1.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < nchan; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= nchan) idx = idx - nchan;
      if (!found && avail[idx]) begin
        found = 1'b1;
        gnt   = idx[chanbits-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    clear_d = '0;
    case (state_q)
      SCAN: begin
        if (enable && found) begin
`ifdef EDGE_COLLECTOR_TIMESTAMP_EN
          data_d = {ts_q, gnt, q[32'(gnt)*bitwidth +: bitwidth]};
`else
          data_d = {gnt, q[32'(gnt)*bitwidth +: bitwidth]};
`endif
          valid_d = 1'b1;
          ptr_d   = (gnt == chanbits'(nchan - 1)) ? '0 : gnt + 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // Clear only after the host has taken the word, so backpressure never loses it.
        if (out_ready) begin
          valid_d = 1'b0;
          clear_d = nchan'(1) << data_q[bitwidth +: chanbits];
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SCAN;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      clear_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      clear_q <= clear_d;
    end
  end

  assign clear     = clear_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != SCAN);

endmodule

// File: tb/tb_edge_buffer_collector.sv
// Bench for edge_buffer_collector: transaction-level model plus directed scenarios with literal expectations.
module tb_edge_buffer_collector;
  localparam int NCH = 4;
  localparam int BW  = 24;
  localparam int CB  = 2;
`ifdef EDGE_COLLECTOR_TIMESTAMP_EN
  localparam int TSW = 16;
`else
  localparam int TSW = 0;
`endif
  localparam int ODW = TSW + CB + BW;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [NCH-1:0]    avail;
  logic [NCH*BW-1:0] q;
  logic [NCH-1:0]    clear;
  logic [ODW-1:0]    out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  edge_buffer_collector #(.nchan(NCH), .bitwidth(BW), .chanbits(CB), .tswidth(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .avail(avail), .q(q),
    .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: a word is either being held for the host, being released, or nothing is pending.
  bit             started = 0;
  bit             m_hold;
  int             m_ch, m_rel, m_ptr, m_c;
  bit             m_found;
  logic [BW-1:0]  m_data;
  logic [15:0]    m_ts, m_gts;

  initial forever begin
    @(posedge clock);
    started = 1;
    if (reset) begin
      m_hold = 0; m_rel = -1; m_ptr = 0; m_ts = '0;
    end else begin
      if (m_hold) begin
        if (out_ready) begin m_hold = 0; m_rel = m_ch; end
      end else if (m_rel >= 0) begin
        m_rel = -1;
      end else if (enable) begin
        m_found = 0;
        for (int k = 0; k < NCH; k++) begin
          m_c = (m_ptr + k) % NCH;
          if (!m_found && avail[m_c]) begin
            m_found = 1; m_hold = 1; m_ch = m_c;
            m_data = q[m_c*BW +: BW]; m_gts = m_ts;
            m_ptr = (m_c + 1) % NCH;
          end
        end
      end
      m_ts = m_ts + 16'd1;
    end
  end

  logic [ODW-1:0] exp_d;
  logic [NCH-1:0] exp_clr;

  initial forever begin
    @(negedge clock);
    if (started) begin
`ifdef EDGE_COLLECTOR_TIMESTAMP_EN
      exp_d = {m_gts, CB'(m_ch), m_data};
`else
      exp_d = {CB'(m_ch), m_data};
`endif
      exp_clr = (m_rel >= 0) ? NCH'(1 << m_rel) : '0;
      chk("model_valid", out_valid, m_hold);
      if (m_hold) chk("model_data", out_data, exp_d);
      chk("model_clear", clear, exp_clr);
      chk("model_busy", busy, m_hold || (m_rel >= 0));
    end
  end

  // One clock cycle; the hold buffers drop avail when their clear pulse is seen.
  logic [NCH-1:0] clr_acc;
  task automatic cyc();
    @(negedge clock);
    clr_acc = clr_acc | clear;
    avail   = avail & ~clear;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(); cyc();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_clear", clear, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", out_data, '0);
    reset = 1'b0;
  endtask

  int got_ch[$];
  int got_t[$];
  logic [BW-1:0] got_d[$];

  task automatic collect(input int n, input int budget);
    int c = 0;
    got_ch.delete(); got_t.delete(); got_d.delete();
    while (got_ch.size() < n && c < budget) begin
      cyc(); c++;
      if (out_valid && out_ready) begin
        got_ch.push_back(int'(out_data[BW +: CB]));
        got_d.push_back(out_data[BW-1:0]);
        got_t.push_back(c);
      end
    end
    chk("collect_count", got_ch.size(), n);
  endtask

  int cnt;
  int exp_order[6] = '{0, 1, 2, 3, 1, 3};

  initial begin
    reset = 1'b1; enable = 1'b1; avail = '0; q = '0; out_ready = 1'b1; clr_acc = '0;
    do_reset();

    // Single word on channel 2
    q[2*BW +: BW] = 24'hABCDEF; avail = 4'b0100;
    cyc();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data[CB+BW-1:0], {2'd2, 24'hABCDEF});
    chk("t1_clear_pre", clear, 4'b0000);
    cyc();
    chk("t1_clear", clear, 4'b0100);
    chk("t1_valid_off", out_valid, 1'b0);
    cyc();
    chk("t1_clear_one", clear, 4'b0000);
    cnt = 0;
    repeat (6) begin cyc(); if (out_valid) cnt++; end
    chk("t1_no_second", cnt, 0);

    // Fairness from reset
    do_reset();
    for (int i = 0; i < NCH; i++) q[i*BW +: BW] = 24'h100000 + 24'(i);
    avail = 4'b1111;
    collect(4, 20);
    for (int i = 0; i < got_ch.size(); i++) begin
      chk("t2_order", got_ch[i], exp_order[i]);
      chk("t2_data", got_d[i], 24'h100000 + 24'(exp_order[i]));
      if (i > 0) chk("t2_spacing", got_t[i] - got_t[i-1], 3);
    end
    cyc(); cyc();
    avail = 4'b1010;
    collect(2, 12);
    for (int i = 0; i < got_ch.size(); i++) chk("t2_order2", got_ch[i], exp_order[4+i]);
    repeat (3) cyc();

    // Backpressure, with enable dropped while the word is presented
    q[0 +: BW] = 24'h5A5A5A; avail = 4'b0001; out_ready = 1'b0;
    cyc();
    chk("t3_valid", out_valid, 1'b1);
    enable = 1'b0;
    cnt = 0;
    repeat (10) begin
      cyc();
      if (out_valid !== 1'b1 || out_data[CB+BW-1:0] !== {2'd0, 24'h5A5A5A} || clear !== 4'b0000) cnt++;
    end
    chk("t3_hold_stable", cnt, 0);
    out_ready = 1'b1;
    cyc();
    chk("t3_clear", clear, 4'b0001);
    chk("t3_valid_off", out_valid, 1'b0);
    cyc();
    chk("t3_clear_off", clear, 4'b0000);
    repeat (2) cyc();

    // Enable gating
    q[0 +: BW] = 24'h0000C3; avail = 4'b0001;
    cnt = 0;
    repeat (20) begin cyc(); if (out_valid) cnt++; end
    chk("t4_gated", cnt, 0);
    enable = 1'b1;
    cyc();
    chk("t4_valid", out_valid, 1'b1);
    chk("t4_data", out_data[CB+BW-1:0], {2'd0, 24'h0000C3});
    cyc();
    chk("t4_clear", clear, 4'b0001);
    repeat (2) cyc();

    // Reset while presenting
    q[1*BW +: BW] = 24'h000042; avail = 4'b0010; out_ready = 1'b0;
    cyc();
    chk("t5_valid", out_valid, 1'b1);
    chk("t5_data", out_data[CB+BW-1:0], {2'd1, 24'h000042});
    clr_acc = '0;
    reset = 1'b1;
    cyc();
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    reset = 1'b0;
    cyc();
    chk("t5_represent", out_valid, 1'b1);
    chk("t5_redata", out_data[CB+BW-1:0], {2'd1, 24'h000042});
    chk("t5_no_clear", clr_acc, 4'b0000);
    out_ready = 1'b1;
    cyc();
    chk("t5_clear", clear, 4'b0010);
    repeat (2) cyc();

`ifdef EDGE_COLLECTOR_TIMESTAMP_EN
    do_reset();
    q[3*BW +: BW] = 24'h777777;
    repeat (5) cyc();
    avail = 4'b1000;
    cyc();
    chk("t6_ts", out_data[ODW-1 -: 16], 16'h0005);
    repeat (3) cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
